// File: rtl/rs_encoder.sv
// Systematic RS(K+16, K) encoder over GF(2^8) (poly 0x11D, alpha = 0x02, generator roots alpha^0..alpha^15).
// Message bytes pass straight through; the 16 parity bytes follow, highest degree first.
module rs_encoder #(
  parameter int K = 188
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Msg_In,
  input  logic       In_Valid,
  output logic       In_Ready,
  output logic [7:0] Code_Out,
  output logic       Out_Valid,
  output logic       Out_Sop,
  output logic       Out_Eop
);

  localparam int NPAR = 16;
  localparam int N = K + NPAR;
  localparam logic [7:0] LAST_MSG = 8'(K - 1);
  localparam logic [7:0] LAST_SYM = 8'(N - 1);

  // g0..g15 of g(x) = prod (x - alpha^i), i = 0..15; g16 = 1 is implicit
  localparam logic [7:0] GEN [NPAR] = '{
    8'd59,  8'd36,  8'd50,  8'd98,  8'd229, 8'd41,  8'd65,  8'd163,
    8'd8,   8'd30,  8'd209, 8'd68,  8'd189, 8'd104, 8'd13,  8'd59
  };

  typedef enum logic {DATA, PARITY} state_t;

  state_t     state;
  logic [7:0] sym_cnt;
  logic [7:0] par [NPAR];
  logic [7:0] fb;
  logic [7:0] fb_prod [NPAR];
  logic       accept;

  // With b a constant, this collapses to a fixed XOR network
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'd0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  assign In_Ready = (state == DATA) && !Reset;
  assign accept   = In_Valid && (state == DATA);
  assign fb       = Msg_In ^ par[NPAR-1];

  always_comb begin
    for (int i = 0; i < NPAR; i++) begin
      fb_prod[i] = gf_mul(fb, GEN[i]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= DATA;
      sym_cnt   <= 8'd0;
      Code_Out  <= 8'd0;
      Out_Valid <= 1'b0;
      Out_Sop   <= 1'b0;
      Out_Eop   <= 1'b0;
      for (int i = 0; i < NPAR; i++) begin
        par[i] <= 8'd0;
      end
    end else begin
      Out_Sop <= 1'b0;
      Out_Eop <= 1'b0;
      case (state)
        DATA: begin
          Out_Valid <= accept;
          if (accept) begin
            Code_Out <= Msg_In;
            Out_Sop  <= (sym_cnt == 8'd0);
            par[0]   <= fb_prod[0];
            for (int i = 1; i < NPAR; i++) begin
              par[i] <= par[i-1] ^ fb_prod[i];
            end
            sym_cnt <= sym_cnt + 8'd1;
            if (sym_cnt == LAST_MSG) state <= PARITY;
          end
        end
        PARITY: begin
          // Shifting zeros in leaves the register cleared for the next block
          Out_Valid <= 1'b1;
          Code_Out  <= par[NPAR-1];
          par[0]    <= 8'd0;
          for (int i = 1; i < NPAR; i++) begin
            par[i] <= par[i-1];
          end
          if (sym_cnt == LAST_SYM) begin
            state   <= DATA;
            sym_cnt <= 8'd0;
            Out_Eop <= 1'b1;
          end else begin
            sym_cnt <= sym_cnt + 8'd1;
          end
        end
        default: state <= DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench for rs_encoder: checks pass-through, framing, handshake and parity via
// hand-computed bytes and codeword syndromes evaluated at alpha^0..alpha^15.
module tb_rs_encoder;

  localparam int K = 188;
  localparam int N = K + 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] Msg_In;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] Code_Out;
  logic       Out_Valid;
  logic       Out_Sop;
  logic       Out_Eop;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  logic [7:0] cap_data [$];
  bit         cap_sop [$];
  bit         cap_eop [$];
  int         cap_cyc [$];

  logic [7:0] msg_buf [K];
  logic [7:0] msg_a [K];
  logic [7:0] golden_a [N];
  logic [7:0] blk [3][K];

  always #5 Clk = ~Clk;

  rs_encoder #(.K(K)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Msg_In   (Msg_In),
    .In_Valid (In_Valid),
    .In_Ready (In_Ready),
    .Code_Out (Code_Out),
    .Out_Valid(Out_Valid),
    .Out_Sop  (Out_Sop),
    .Out_Eop  (Out_Eop)
  );

  // Output monitor, sampling half a cycle away from the active edge
  always @(negedge Clk) begin
    cycle++;
    if (Out_Valid === 1'b1) begin
      cap_data.push_back(Code_Out);
      cap_sop.push_back(Out_Sop === 1'b1);
      cap_eop.push_back(Out_Eop === 1'b1);
      cap_cyc.push_back(cycle);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation timeout");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'd0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  // OR of S1..S16; the first captured byte is the highest-degree coefficient
  function automatic logic [7:0] syndrome_or(input int start);
    logic [7:0] acc;
    logic [7:0] root;
    logic [7:0] s;
    acc = 8'd0;
    root = 8'd1;
    for (int i = 0; i < 16; i++) begin
      s = 8'd0;
      for (int j = 0; j < N; j++) s = gmul(s, root) ^ cap_data[start + j];
      acc = acc | s;
      root = gmul(root, 8'h02);
    end
    return acc;
  endfunction

  function automatic int msg_mismatches(input int start);
    int n;
    n = 0;
    for (int j = 0; j < K; j++) if (cap_data[start + j] !== msg_buf[j]) n++;
    return n;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      In_Valid = 1'b0;
    end
    #1;
  endtask

  task automatic run_block(input bit gaps, input bit parity_valid, output int ready_low);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    ready_low = 0;
    while (idx < K && cyc < 4 * K) begin
      @(negedge Clk);
      if (gaps && (cyc % 3 == 2)) begin
        In_Valid = 1'b0;
        Msg_In = 8'h5A;
      end else begin
        In_Valid = 1'b1;
        Msg_In = msg_buf[idx];
      end
      if (In_Valid && In_Ready) idx++;
      cyc++;
    end
    tests_run++;
    if (idx !== K) begin
      tests_failed++;
      $display("[TB] FAIL accept_count got=%0d want=%0d", idx, K);
    end
    for (int p = 0; p < 16; p++) begin
      @(negedge Clk);
      In_Valid = parity_valid;
      Msg_In = 8'hA5;
      if (In_Ready !== 1'b1) ready_low++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    In_Valid = 1'b1;
    Msg_In = 8'hFF;
    repeat (3) @(negedge Clk);
    tests_run++;
    if ({Code_Out, Out_Valid, Out_Sop, Out_Eop} !== 11'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got=%h want=0", {Code_Out, Out_Valid, Out_Sop, Out_Eop});
    end
    tests_run++;
    if (In_Ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready got=%b want=0", In_Ready);
    end
    @(negedge Clk);
    Reset = 1'b0;
    In_Valid = 1'b0;
    #1;
    tests_run++;
    if (In_Ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ready_after_reset got=%b want=1", In_Ready);
    end
  endtask

  task automatic test_all_zero();
    int start, rl, nz, nsop, neop;
    for (int j = 0; j < K; j++) msg_buf[j] = 8'd0;
    start = cap_data.size();
    run_block(1'b0, 1'b0, rl);
    idle(3);
    tests_run++;
    if (cap_data.size() - start !== N) begin
      tests_failed++;
      $display("[TB] FAIL zero_count got=%0d want=%0d", cap_data.size() - start, N);
    end else begin
      nz = 0; nsop = 0; neop = 0;
      for (int j = 0; j < N; j++) begin
        if (cap_data[start + j] !== 8'd0) nz++;
        if (cap_sop[start + j]) nsop++;
        if (cap_eop[start + j]) neop++;
      end
      tests_run++;
      if (nz !== 0) begin
        tests_failed++;
        $display("[TB] FAIL zero_data nonzero=%0d want=0", nz);
      end
      tests_run++;
      if (cap_sop[start] !== 1'b1 || nsop !== 1) begin
        tests_failed++;
        $display("[TB] FAIL zero_sop first=%b count=%0d want first=1 count=1", cap_sop[start], nsop);
      end
      tests_run++;
      if (cap_eop[start + N - 1] !== 1'b1 || neop !== 1) begin
        tests_failed++;
        $display("[TB] FAIL zero_eop last=%b count=%0d want last=1 count=1", cap_eop[start + N - 1], neop);
      end
      tests_run++;
      if (cap_cyc[start + N - 1] - cap_cyc[start] !== N - 1) begin
        tests_failed++;
        $display("[TB] FAIL zero_contiguous span=%0d want=%0d", cap_cyc[start + N - 1] - cap_cyc[start], N - 1);
      end
    end
    tests_run++;
    if (rl !== 16) begin
      tests_failed++;
      $display("[TB] FAIL zero_ready_low got=%0d want=16", rl);
    end
  endtask

  task automatic test_impulse();
    int start, rl;
    logic [7:0] exp_par [16];
    exp_par = '{8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209, 8'd30, 8'd8,
                8'd163, 8'd65, 8'd41, 8'd229, 8'd98, 8'd50, 8'd36, 8'd59};
    for (int j = 0; j < K; j++) msg_buf[j] = 8'd0;
    msg_buf[K-1] = 8'd1;
    start = cap_data.size();
    run_block(1'b0, 1'b0, rl);
    idle(3);
    tests_run++;
    if (cap_data.size() - start !== N) begin
      tests_failed++;
      $display("[TB] FAIL impulse_count got=%0d want=%0d", cap_data.size() - start, N);
    end else begin
      for (int p = 0; p < 16; p++) begin
        tests_run++;
        if (cap_data[start + K + p] !== exp_par[p]) begin
          tests_failed++;
          $display("[TB] FAIL impulse_parity[%0d] got=%0d want=%0d", p, cap_data[start + K + p], exp_par[p]);
        end
      end
      tests_run++;
      if (msg_mismatches(start) !== 0) begin
        tests_failed++;
        $display("[TB] FAIL impulse_msg mismatches=%0d want=0", msg_mismatches(start));
      end
    end
  endtask

  task automatic test_gaps();
    int start, rl, diff;
    for (int j = 0; j < K; j++) begin
      msg_a[j] = 8'($urandom_range(0, 255));
      msg_buf[j] = msg_a[j];
    end
    start = cap_data.size();
    run_block(1'b0, 1'b0, rl);
    idle(3);
    tests_run++;
    if (cap_data.size() - start !== N) begin
      tests_failed++;
      $display("[TB] FAIL nogap_count got=%0d want=%0d", cap_data.size() - start, N);
      for (int j = 0; j < N; j++) golden_a[j] = 8'hXX;
    end else begin
      for (int j = 0; j < N; j++) golden_a[j] = cap_data[start + j];
      tests_run++;
      if (msg_mismatches(start) !== 0) begin
        tests_failed++;
        $display("[TB] FAIL nogap_msg mismatches=%0d want=0", msg_mismatches(start));
      end
      tests_run++;
      if (syndrome_or(start) !== 8'd0) begin
        tests_failed++;
        $display("[TB] FAIL nogap_syndrome or=%h want=00", syndrome_or(start));
      end
    end
    start = cap_data.size();
    run_block(1'b1, 1'b1, rl);
    idle(3);
    tests_run++;
    if (rl !== 16) begin
      tests_failed++;
      $display("[TB] FAIL gap_ready_low got=%0d want=16", rl);
    end
    tests_run++;
    if (cap_data.size() - start !== N) begin
      tests_failed++;
      $display("[TB] FAIL gap_count got=%0d want=%0d", cap_data.size() - start, N);
    end else begin
      diff = 0;
      for (int j = 0; j < N; j++) if (cap_data[start + j] !== golden_a[j]) diff++;
      tests_run++;
      if (diff !== 0) begin
        tests_failed++;
        $display("[TB] FAIL gap_vs_nogap differing_bytes=%0d want=0", diff);
      end
    end
  endtask

  task automatic test_back_to_back();
    int start, rl, base;
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < K; j++) blk[b][j] = 8'($urandom_range(0, 255));
    start = cap_data.size();
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < K; j++) msg_buf[j] = blk[b][j];
      run_block(1'b0, 1'b1, rl);
    end
    idle(3);
    tests_run++;
    if (cap_data.size() - start !== 3 * N) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count got=%0d want=%0d", cap_data.size() - start, 3 * N);
    end else begin
      for (int b = 0; b < 3; b++) begin
        base = start + b * N;
        for (int j = 0; j < K; j++) msg_buf[j] = blk[b][j];
        tests_run++;
        if (msg_mismatches(base) !== 0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_msg[%0d] mismatches=%0d want=0", b, msg_mismatches(base));
        end
        tests_run++;
        if (syndrome_or(base) !== 8'd0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_syndrome[%0d] or=%h want=00", b, syndrome_or(base));
        end
        tests_run++;
        if (cap_sop[base] !== 1'b1 || cap_eop[base + N - 1] !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL b2b_frame[%0d] sop=%b eop=%b want 1 1", b, cap_sop[base], cap_eop[base + N - 1]);
        end
        if (b < 2) begin
          tests_run++;
          if (cap_cyc[base + N] - cap_cyc[base + N - 1] !== 1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_bubble[%0d] gap=%0d want=1", b, cap_cyc[base + N] - cap_cyc[base + N - 1]);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int start, rl, diff;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      In_Valid = 1'b1;
      Msg_In = 8'($urandom_range(0, 255));
    end
    @(negedge Clk);
    Reset = 1'b1;
    In_Valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      tests_run++;
      if ({Code_Out, Out_Valid, Out_Sop, Out_Eop, In_Ready} !== 12'd0) begin
        tests_failed++;
        $display("[TB] FAIL midreset_outputs got=%h want=0", {Code_Out, Out_Valid, Out_Sop, Out_Eop, In_Ready});
      end
    end
    @(negedge Clk);
    Reset = 1'b0;
    In_Valid = 1'b0;
    idle(1);
    for (int j = 0; j < K; j++) msg_buf[j] = msg_a[j];
    start = cap_data.size();
    run_block(1'b0, 1'b0, rl);
    idle(3);
    tests_run++;
    if (cap_data.size() - start !== N) begin
      tests_failed++;
      $display("[TB] FAIL fresh_count got=%0d want=%0d", cap_data.size() - start, N);
    end else begin
      diff = 0;
      for (int j = 0; j < N; j++) if (cap_data[start + j] !== golden_a[j]) diff++;
      tests_run++;
      if (diff !== 0) begin
        tests_failed++;
        $display("[TB] FAIL fresh_vs_golden differing_bytes=%0d want=0", diff);
      end
      tests_run++;
      if (cap_sop[start] !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL fresh_sop got=%b want=1", cap_sop[start]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    In_Valid = 1'b0;
    Msg_In = 8'd0;
    test_reset();
    test_all_zero();
    test_impulse();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rs_encoder.md
# rs_encoder

Systematic RS(204,188) Reed–Solomon encoder (shortened from RS(255,239), t = 8) for the DVB-T outer-coding chain. It accepts 188 message bytes per block through a valid/ready handshake. It emits the 204-byte codeword: the message bytes unchanged, followed by 16 parity bytes. Its output is the stream the syndrome/decoder path consumes, and it doubles as the in-house golden source for decoder benches.

## Interface
Parameters:
- K, default 188: message symbols per block. The parity count is fixed at 16, so N = K+16. Any K from 1 to 239 is legal; small K is used only for quick sims.

Ports:
- Clk  input  1  rising-edge clock, the only clock.
- Reset  input  1  synchronous, active-high reset.
- Msg_In  input  8  message symbol, GF(2^8) element.
- In_Valid  input  1  Msg_In holds a symbol this cycle.
- In_Ready  output  1  encoder accepts a symbol this cycle.
- Code_Out  output  8  codeword symbol.
- Out_Valid  output  1  Code_Out holds a symbol this cycle.
- Out_Sop  output  1  Code_Out is codeword symbol 0.
- Out_Eop  output  1  Code_Out is codeword symbol N-1 (the last parity byte).

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02.
- Generator: g(x) = ∏_{i=0..15}(x − α^i). The roots α^0..α^15 match the decoder's S1..S16.
  - Coefficients g0..g15 = 59,36,50,98,229,41,65,163,8,30,209,68,189,104,13,59; g16 = 1.
  - The constant multipliers are fixed XOR networks; there are no general multipliers.
- Parity register: 16 × 8-bit cells r0..r15, LFSR division by g(x).
- FSM has two states, DATA and PARITY.
- DATA state:
  - In_Ready = 1.
  - On accept (In_Valid & In_Ready):
    - fb = Msg_In ^ r15.
    - r0 <= g0·fb; ri <= r(i-1) ^ gi·fb for i = 1..15.
    - Code_Out <= Msg_In, Out_Valid <= 1.
    - sym_cnt <= sym_cnt+1.
  - When no symbol is accepted: LFSR and sym_cnt hold, Out_Valid <= 0.
  - On the K-th accept: go to PARITY.
- PARITY state:
  - In_Ready = 0; In_Valid is ignored and Msg_In is not consumed.
  - Each cycle: Code_Out <= r15; ri <= r(i-1); r0 <= 0; Out_Valid <= 1.
  - Parity leaves highest-degree first (p15..p0).
  - After 16 cycles: go to DATA, sym_cnt <= 0. The LFSR is then all-zero, so no explicit clear is needed.
- sym_cnt: 8 bits, counts 0..N-1 and wraps to 0 at the end of each block.
- Out_Sop = 1 with the first message symbol; Out_Eop = 1 with the 16th parity symbol. Each is a single-cycle pulse, qualified by Out_Valid.
- Reset:
  - Synchronous, and wins over every other event.
  - State <= DATA, sym_cnt <= 0, r0..r15 <= 0.
  - Code_Out = 0, Out_Valid = 0, Out_Sop = 0, Out_Eop = 0.
  - In_Ready = 0 while Reset is high.
  - A reset mid-block discards the partial block; the next accepted symbol is symbol 0 of a new block.

## Timing
- Latency: a symbol accepted at edge e appears on Code_Out/Out_Valid in the cycle after e (one register stage).
- In_Ready is registered-state-derived: it drops in the cycle after the K-th accept edge and rises in the cycle after the Out_Eop edge.
- Throughput: a fully streamed block takes K+16 cycles. Back-to-back blocks have no bubble: Out_Eop of block n can be followed directly by Out_Sop of block n+1 in the next cycle, if In_Valid is high.
- During DATA, output gaps mirror input gaps one cycle later. The PARITY burst is always 16 contiguous Out_Valid cycles.
- There is no downstream backpressure; the consumer must sink every Out_Valid cycle.
- First cycle after Reset deasserts: In_Ready = 1.

## Test plan
- All-zero message, K=188, In_Valid held high:
  - Required: 204 Out_Valid cycles, all Code_Out = 0.
  - Out_Sop high on cycle 1 after the first accept; Out_Eop high on cycle 204.
  - In_Ready low for exactly 16 cycles.
- 187 zeros then 0x01:
  - Required parity = 59,13,104,189,68,209,30,8,163,65,41,229,98,50,36,59, i.e. the g coefficients, highest degree first.
- Random message with In_Valid gaps inserted every 3rd cycle, plus In_Valid held high during PARITY:
  - Required: codeword byte-identical to the gap-free run and to the MATLAB rsenc golden file.
  - No extra symbols are consumed during PARITY.
- Three back-to-back random blocks:
  - Required: each matches golden.
  - Out_Eop is immediately followed by Out_Sop.
  - Each codeword fed into the syndrome block yields S1..S16 = 0.
- Reset pulsed after 100 accepted symbols, then a fresh block:
  - Required: all outputs 0 during reset.
  - The fresh block's codeword matches golden, with no residue from the aborted block.
